fir_complex_decim: RTL and testbench



---
 rtl/fir_complex_decim_if.sv | 33 +++
 rtl/fir_complex_decim.sv | 156 +++++++++++++++
 tb/tb_fir_complex_decim.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_complex_decim_if.sv
// FIFO-side bus of fir_complex_decim.
// Handshake: the I/Q sources present data with *_empty low. A sample pair
// is transferred on the rising edge where i_rd_en/q_rd_en are high, and
// both enables are only ever high together. The result sinks accept
// real_out/imag_out on the rising edge where real_wr_en/imag_wr_en are high,
// and the write enables are only high together while both *_full are low.
// "master" is the FIFO side; "slave" is the filter.
interface fir_complex_decim_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] i_in;
    logic                  i_empty;
    logic                  i_rd_en;
    logic [DATA_WIDTH-1:0] q_in;
    logic                  q_empty;
    logic                  q_rd_en;
    logic [DATA_WIDTH-1:0] real_out;
    logic                  real_wr_en;
    logic                  real_full;
    logic [DATA_WIDTH-1:0] imag_out;
    logic                  imag_wr_en;
    logic                  imag_full;

    modport master (
        output i_in, i_empty, q_in, q_empty, real_full, imag_full,
        input  i_rd_en, q_rd_en, real_out, real_wr_en, imag_out, imag_wr_en
    );

    modport slave (
        input  i_in, i_empty, q_in, q_empty, real_full, imag_full,
        output i_rd_en, q_rd_en, real_out, real_wr_en, imag_out, imag_wr_en
    );
endinterface

// File: rtl/fir_complex_decim.sv
// Complex FIR with integer decimation and a single time-multiplexed MAC.
// Optional output saturation is enabled by defining FIR_COMPLEX_SAT_EN;
// otherwise the output is the wrapped low DATA_WIDTH accumulator bits.
module fir_complex_decim #(
    parameter int DATA_WIDTH = 32,
    parameter int TAP_NUMBER = 20,
    parameter int DECIMATION = 1,
    parameter int FRAC_BITS  = 10,
    parameter logic [TAP_NUMBER-1:0][DATA_WIDTH-1:0] REAL_COEFF = '0,
    parameter logic [TAP_NUMBER-1:0][DATA_WIDTH-1:0] IMAG_COEFF = '0
) (
    input  logic                clock,
    input  logic                reset,
    fir_complex_decim_if.slave  bus,
    output logic [1:0]          state_dbg
);
    localparam int ACC_W  = DATA_WIDTH + $clog2(2 * TAP_NUMBER);
    localparam int PROD_W = 2 * DATA_WIDTH;
    localparam int TW     = $clog2(TAP_NUMBER);
    localparam int DW     = (DECIMATION > 1) ? $clog2(DECIMATION) : 1;

    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_READ  = 2'd0,
        ST_RUN   = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [DATA_WIDTH-1:0] hist_i [TAP_NUMBER];
    logic [DATA_WIDTH-1:0] hist_q [TAP_NUMBER];
    logic [TW-1:0]         wr_ptr;
    logic [DW-1:0]         dec_cnt;
    logic [TW-1:0]         tap_cnt;
    logic signed [ACC_W-1:0] acc_r, acc_i;

    logic rd_fire, wr_fire, dec_last, tap_last;
    logic [TW-1:0] rd_idx;
    logic signed [DATA_WIDTH-1:0] xr, xi, cr, ci;
    logic signed [PROD_W-1:0] p_rr, p_ii, p_ri, p_ir;
    logic signed [PROD_W-1:0] s_rr, s_ii, s_ri, s_ir;
    logic [PROD_W:0] term_r, term_i;
    logic [DATA_WIDTH-1:0] res_r, res_i;

    assign dec_last  = (dec_cnt == DW'(DECIMATION - 1));
    assign tap_last  = (tap_cnt == TW'(TAP_NUMBER - 1));
    assign state_dbg = state;

    // Reduce the full-width accumulator to the output width.
    function automatic logic [DATA_WIDTH-1:0] to_out(input logic signed [ACC_W-1:0] a);
`ifdef FIR_COMPLEX_SAT_EN
        if (a > SAT_MAX) begin
            return SAT_MAX[DATA_WIDTH-1:0];
        end else if (a < SAT_MIN) begin
            return SAT_MIN[DATA_WIDTH-1:0];
        end else begin
            return a[DATA_WIDTH-1:0];
        end
`else
        return a[DATA_WIDTH-1:0];
`endif
    endfunction

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_READ;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: READ until the DECIMATION-th sample, TAP_NUMBER MAC cycles, one write.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_READ:  if (rd_fire && dec_last) state_nxt = ST_RUN;
            ST_RUN:   if (tap_last) state_nxt = ST_WRITE;
            ST_WRITE: if (wr_fire) state_nxt = ST_READ;
            default:  state_nxt = ST_READ;
        endcase
    end

    // Outputs: enables are combinational from the FIFO flags, data is zero unless writing.
    always_comb begin
        rd_fire        = !reset && (state == ST_READ) && !bus.i_empty && !bus.q_empty;
        wr_fire        = !reset && (state == ST_WRITE) && !bus.real_full && !bus.imag_full;
        bus.i_rd_en    = rd_fire;
        bus.q_rd_en    = rd_fire;
        bus.real_wr_en = wr_fire;
        bus.imag_wr_en = wr_fire;
        bus.real_out   = wr_fire ? res_r : '0;
        bus.imag_out   = wr_fire ? res_i : '0;
    end

    // MAC operand selection: tap k reads the sample k positions older than the newest.
    always_comb begin
        int t;
        t = int'(wr_ptr) - 1 - int'(tap_cnt);
        if (t < 0) t = t + TAP_NUMBER;
        rd_idx = TW'(t);
        xr     = hist_i[rd_idx];
        xi     = hist_q[rd_idx];
        cr     = REAL_COEFF[tap_cnt];
        ci     = IMAG_COEFF[tap_cnt];
        p_rr   = cr * xr;
        p_ii   = ci * xi;
        p_ri   = cr * xi;
        p_ir   = ci * xr;
        s_rr   = p_rr >>> FRAC_BITS;
        s_ii   = p_ii >>> FRAC_BITS;
        s_ri   = p_ri >>> FRAC_BITS;
        s_ir   = p_ir >>> FRAC_BITS;
        term_r = {s_rr[PROD_W-1], s_rr} - {s_ii[PROD_W-1], s_ii};
        term_i = {s_ri[PROD_W-1], s_ri} + {s_ir[PROD_W-1], s_ir};
        res_r  = to_out(acc_r);
        res_i  = to_out(acc_i);
    end

    // Datapath: history capture, decimation/tap counters and accumulation.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < TAP_NUMBER; k++) begin
                hist_i[k] <= '0;
                hist_q[k] <= '0;
            end
            wr_ptr  <= '0;
            dec_cnt <= '0;
            tap_cnt <= '0;
            acc_r   <= '0;
            acc_i   <= '0;
        end else begin
            if (rd_fire) begin
                hist_i[wr_ptr] <= bus.i_in;
                hist_q[wr_ptr] <= bus.q_in;
                wr_ptr  <= (wr_ptr == TW'(TAP_NUMBER - 1)) ? '0 : wr_ptr + 1'b1;
                dec_cnt <= dec_last ? '0 : dec_cnt + 1'b1;
                if (dec_last) begin
                    acc_r   <= '0;
                    acc_i   <= '0;
                    tap_cnt <= '0;
                end
            end
            if (state == ST_RUN) begin
                acc_r   <= acc_r + $signed(term_r[ACC_W-1:0]);
                acc_i   <= acc_i + $signed(term_i[ACC_W-1:0]);
                tap_cnt <= tap_last ? '0 : tap_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fir_complex_decim.sv
// Bench for fir_complex_decim: FIFO drivers, a reference model computing each
// decimated output straight from the sample history, and an expected queue.
module tb_fir_complex_decim;
  localparam int W     = 16;
  localparam int T     = 6;
  localparam int D     = 3;
  localparam int F     = 4;
  localparam int ACC_W = W + $clog2(2 * T);

  // Index 0 (last element) is the tap applied to the newest sample.
  localparam logic [T-1:0][W-1:0] RC = {16'd7, 16'd12000, -16'sd1000, 16'd300, -16'sd32, 16'd16};
  localparam logic [T-1:0][W-1:0] IC = {16'd30, -16'sd9000, 16'd0, -16'sd200, 16'd5, 16'd16};

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] state_dbg;

  fir_complex_decim_if #(.DATA_WIDTH(W)) bus ();

  fir_complex_decim #(
    .DATA_WIDTH(W), .TAP_NUMBER(T), .DECIMATION(D), .FRAC_BITS(F),
    .REAL_COEFF(RC), .IMAG_COEFF(IC)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_r[$];
  logic [W-1:0] exp_i[$];
  logic [W-1:0] src_i[$];
  logic [W-1:0] src_q[$];
  logic [W-1:0] h_i[$];
  logic [W-1:0] h_q[$];
  int n_acc   = 0;
  int cyc     = 0;
  int cap_cyc = 0;
  int stall_pct = 0;
  int full_pct  = 0;
  bit hold_full = 0;

  // reference model
  function automatic logic [W-1:0] fit(input longint a);
    longint m;
    logic [63:0] b;
    m = a & ((64'sd1 <<< ACC_W) - 1);
    if (m >= (64'sd1 <<< (ACC_W - 1))) m = m - (64'sd1 <<< ACC_W);
`ifdef FIR_COMPLEX_SAT_EN
    if (m > (64'sd1 <<< (W - 1)) - 1) m = (64'sd1 <<< (W - 1)) - 1;
    if (m < -(64'sd1 <<< (W - 1))) m = -(64'sd1 <<< (W - 1));
`endif
    b = m;
    return b[W-1:0];
  endfunction

  function automatic void model_accept(input logic [W-1:0] si, input logic [W-1:0] sq);
    longint ar, ai, xr, xq, cr, ci;
    int n;
    h_i.push_back(si);
    h_q.push_back(sq);
    n_acc++;
    if (n_acc % D == 0) begin
      ar = 0;
      ai = 0;
      n = h_i.size();
      for (int k = 0; k < T; k++) begin
        xr = 0;
        xq = 0;
        if (n - 1 - k >= 0) begin
          xr = longint'($signed(h_i[n-1-k]));
          xq = longint'($signed(h_q[n-1-k]));
        end
        cr = longint'($signed(RC[k]));
        ci = longint'($signed(IC[k]));
        ar += ((cr * xr) >>> F) - ((ci * xq) >>> F);
        ai += ((cr * xq) >>> F) + ((ci * xr) >>> F);
      end
      exp_r.push_back(fit(ar));
      exp_i.push_back(fit(ai));
      cap_cyc = cyc;
    end
  endfunction

  function automatic void model_reset();
    h_i.delete();
    h_q.delete();
    exp_r.delete();
    exp_i.delete();
    n_acc = 0;
  endfunction

  // driver: one clock cycle, starting and ending at a falling edge
  task automatic step();
    logic exp_rd, exp_wr;
    bus.i_empty   = (src_i.size() == 0) || ($urandom_range(0, 99) < stall_pct);
    bus.q_empty   = (src_q.size() == 0) || ($urandom_range(0, 99) < stall_pct);
    bus.i_in      = (src_i.size() != 0) ? src_i[0] : W'($urandom);
    bus.q_in      = (src_q.size() != 0) ? src_q[0] : W'($urandom);
    bus.real_full = hold_full || ($urandom_range(0, 99) < full_pct);
    bus.imag_full = hold_full || ($urandom_range(0, 99) < full_pct);
    #1;
    exp_rd = (exp_r.size() == 0) && !bus.i_empty && !bus.q_empty;
    exp_wr = (exp_r.size() != 0) && !bus.real_full && !bus.imag_full && (cyc >= cap_cyc + T + 1);
    checks++;
    if (bus.i_rd_en !== exp_rd || bus.q_rd_en !== exp_rd) begin
      errors++;
      $display("FAIL rd_en cyc=%0d i_rd_en=%b q_rd_en=%b expected=%b", cyc, bus.i_rd_en, bus.q_rd_en, exp_rd);
    end
    checks++;
    if (bus.real_wr_en !== exp_wr || bus.imag_wr_en !== exp_wr) begin
      errors++;
      $display("FAIL wr_en cyc=%0d real_wr_en=%b imag_wr_en=%b expected=%b", cyc, bus.real_wr_en, bus.imag_wr_en, exp_wr);
    end
    if (exp_wr) begin
      checks++;
      if (bus.real_out !== exp_r[0] || bus.imag_out !== exp_i[0]) begin
        errors++;
        $display("FAIL result cyc=%0d got=(%0d,%0d) expected=(%0d,%0d)", cyc,
                 $signed(bus.real_out), $signed(bus.imag_out), $signed(exp_r[0]), $signed(exp_i[0]));
      end
      void'(exp_r.pop_front());
      void'(exp_i.pop_front());
    end else begin
      checks++;
      if (bus.real_out !== '0 || bus.imag_out !== '0) begin
        errors++;
        $display("FAIL idle_out cyc=%0d got=(%h,%h) expected=(0,0)", cyc, bus.real_out, bus.imag_out);
      end
    end
    if (exp_rd) begin
      model_accept(src_i.pop_front(), src_q.pop_front());
    end
    @(posedge clock);
    @(negedge clock);
    cyc++;
  endtask

  task automatic push(input logic [W-1:0] si, input logic [W-1:0] sq);
    src_i.push_back(si);
    src_q.push_back(sq);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((src_i.size() != 0 || exp_r.size() != 0) && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (src_i.size() != 0 || exp_r.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout pending_in=%0d pending_out=%0d expected=0", src_i.size(), exp_r.size());
      src_i.delete();
      src_q.delete();
      exp_r.delete();
      exp_i.delete();
    end
  endtask

  task automatic check_quiet(input string tag);
    checks++;
    if (bus.i_rd_en !== 1'b0 || bus.q_rd_en !== 1'b0 || bus.real_wr_en !== 1'b0 ||
        bus.imag_wr_en !== 1'b0 || bus.real_out !== '0 || bus.imag_out !== '0) begin
      errors++;
      $display("FAIL %s rd=%b%b wr=%b%b out=(%h,%h) expected all 0", tag, bus.i_rd_en, bus.q_rd_en,
               bus.real_wr_en, bus.imag_wr_en, bus.real_out, bus.imag_out);
    end
  endtask

  // scenarios
  task automatic test_reset();
    reset = 1'b1;
    bus.i_empty = 1'b0;
    bus.q_empty = 1'b0;
    bus.i_in = 16'h1234;
    bus.q_in = 16'h4321;
    bus.real_full = 1'b0;
    bus.imag_full = 1'b0;
    #1;
    check_quiet("reset_outputs");
    @(posedge clock);
    @(negedge clock);
    check_quiet("reset_held");
    reset = 1'b0;
  endtask

  task automatic test_impulse();
    push(16'd16, 16'd0);
    for (int k = 0; k < 2 * T + 2; k++) push(16'd0, 16'd0);
    drain(400);
  endtask

  task automatic test_rotation();
    push(16'd5, 16'd7);
    push(16'd0, 16'd0);
    push(16'd0, 16'd0);
    push(-16'sd80, 16'd48);
    for (int k = 0; k < 8; k++) push(16'd0, 16'd0);
    drain(400);
  endtask

  task automatic test_constant();
    for (int k = 0; k < 4 * D; k++) push(16'd3, -16'sd3);
    drain(400);
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 3 * D; k++) push(16'd32767, 16'd32767);
    for (int k = 0; k < 3 * D; k++) push(16'h8000, 16'd32767);
    drain(400);
  endtask

  task automatic test_random();
    stall_pct = 25;
    full_pct  = 30;
    for (int k = 0; k < 150; k++) push(W'($urandom), W'($urandom_range(0, 2000) - 1000));
    drain(3000);
    stall_pct = 0;
    full_pct  = 0;
  endtask

  task automatic test_backpressure();
    int n;
    for (int k = 0; k < 2 * D; k++) push(W'($urandom), W'($urandom));
    n = 0;
    while (exp_r.size() == 0 && n < 50) begin
      step();
      n++;
    end
    hold_full = 1'b1;
    for (int k = 0; k < T + 11; k++) step();
    hold_full = 1'b0;
    drain(400);
  endtask

  task automatic test_reset_mid_run();
    int n;
    for (int k = 0; k < D; k++) push(16'd20000, -16'sd20000);
    n = 0;
    while (exp_r.size() == 0 && n < 50) begin
      step();
      n++;
    end
    step();
    step();
    #2;
    reset = 1'b1;
    #1;
    check_quiet("reset_mid_run");
    model_reset();
    @(posedge clock);
    @(negedge clock);
    check_quiet("reset_mid_run_held");
    reset = 1'b0;
    for (int k = 0; k < 2 * D + 1; k++) push(W'($urandom_range(0, 200)), W'($urandom_range(0, 200)));
    drain(400);
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_rotation();
    test_constant();
    test_saturation();
    test_backpressure();
    test_random();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule
